// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter.
// Runs the request-to-send handshake, shifts out data and parity on device clock falls,
// checks the device ACK, retries on NAK and reports errors. Both lines are open drain.
module ps2_host_tx #(
    parameter int unsigned REQUEST_CYCLES = 12000,
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 200000,
    parameter int unsigned MAX_RETRIES    = 2,
    parameter bit          ODD_PARITY     = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       tx_abort,
    output logic       tx_done,
    output logic       tx_err,
    output logic [1:0] err_code,
    output logic       busy,
    inout  wire        ps2d,
    inout  wire        ps2c
);

    localparam int unsigned RcW = (REQUEST_CYCLES > 1) ? $clog2(REQUEST_CYCLES) : 1;
    localparam int unsigned WdW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned RtW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

    localparam logic [RcW-1:0] RcLast = RcW'(REQUEST_CYCLES - 1);
    localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT_CYCLES - 1);
    localparam logic [RtW-1:0] RtMax  = RtW'(MAX_RETRIES);

    typedef enum logic [2:0] {
        StIdle, StRequest, StStart, StData, StStop, StAck, StAckHi
    } state_e;

    state_e                r_state, w_state_next;
    logic [1:0]            r_d_sync;
    logic [FILTER_LEN-1:0] r_c_shift;
    logic                  r_c_filt;
    logic                  r_fall;
    logic [8:0]            r_frame;
    logic [8:0]            r_shift;
    logic [3:0]            r_bit;
    logic [RcW-1:0]        r_rc;
    logic [WdW-1:0]        r_wd;
    logic [RtW-1:0]        r_retries;
    logic                  r_nak;
    logic                  r_done;
    logic                  r_err;
    logic [1:0]            r_err_code;

    logic w_accept, w_active, w_done_set, w_err_set, w_err_to, w_retry;
    logic w_parity, w_c_low, w_d_low;

    assign w_accept = tx_valid && tx_ready;
    assign w_parity = ODD_PARITY ? ~^tx_data : ^tx_data;
    assign w_active = (r_state inside {StStart, StData, StStop, StAck, StAckHi});

    // Input conditioning: data synchroniser, clock glitch filter and registered fall strobe.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_d_sync  <= 2'b11;
            r_c_shift <= '1;
            r_c_filt  <= 1'b1;
            r_fall    <= 1'b0;
        end else begin
            r_d_sync  <= {r_d_sync[0], ps2d};
            r_c_shift <= {r_c_shift[FILTER_LEN-2:0], ps2c};
            if (&r_c_shift) begin
                r_c_filt <= 1'b1;
            end else if (~|r_c_shift) begin
                r_c_filt <= 1'b0;
            end
            r_fall <= r_c_filt && (~|r_c_shift);
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; watchdog then abort override the normal transitions.
    always_comb begin
        w_state_next = r_state;
        w_done_set   = 1'b0;
        w_err_set    = 1'b0;
        w_err_to     = 1'b0;
        w_retry      = 1'b0;
        case (r_state)
            StIdle:    if (w_accept) w_state_next = StRequest;
            StRequest: if (r_rc == RcLast) w_state_next = StStart;
            StStart:   if (r_fall) w_state_next = StData;
            StData:    if (r_fall && (r_bit == 4'd8)) w_state_next = StStop;
            StStop:    if (r_fall) w_state_next = StAck;
            StAck:     if (r_fall) w_state_next = StAckHi;
            StAckHi: begin
                if (r_c_filt) begin
                    if (!r_nak) begin
                        w_state_next = StIdle;
                        w_done_set   = 1'b1;
                    end else if (r_retries != RtMax) begin
                        w_state_next = StRequest;
                        w_retry      = 1'b1;
                    end else begin
                        w_state_next = StIdle;
                        w_err_set    = 1'b1;
                    end
                end
            end
            default: w_state_next = StIdle;
        endcase
        if (w_active && !r_fall && (r_wd == WdLast)) begin
            w_state_next = StIdle;
            w_done_set   = 1'b0;
            w_retry      = 1'b0;
            w_err_set    = 1'b1;
            w_err_to     = 1'b1;
        end
        if (tx_abort && (r_state != StIdle)) begin
            w_state_next = StIdle;
            w_done_set   = 1'b0;
            w_retry      = 1'b0;
            w_err_set    = 1'b0;
            w_err_to     = 1'b0;
        end
    end

    // Datapath: frame capture, bit shifting, counters, ACK sample and result pulses.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_frame    <= '0;
            r_shift    <= '0;
            r_bit      <= '0;
            r_rc       <= '0;
            r_wd       <= '0;
            r_retries  <= '0;
            r_nak      <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= 2'b00;
        end else begin
            r_done <= w_done_set;
            r_err  <= w_err_set;
            if (w_accept) begin
                r_frame    <= {w_parity, tx_data};
                r_retries  <= '0;
                r_err_code <= 2'b00;
            end else if (w_err_set) begin
                r_err_code <= w_err_to ? 2'b01 : 2'b10;
            end
            if (w_retry) begin
                r_retries <= r_retries + RtW'(1);
            end
            if ((r_state == StRequest) && (w_state_next == StRequest)) begin
                r_rc <= r_rc + RcW'(1);
            end else begin
                r_rc <= '0;
            end
            // Watchdog restarts on each fall and whenever the active phase is (re)entered.
            if (w_active && (w_state_next inside {StStart, StData, StStop, StAck, StAckHi})
                && !r_fall) begin
                r_wd <= r_wd + WdW'(1);
            end else begin
                r_wd <= '0;
            end
            if (r_state == StRequest) begin
                r_shift <= r_frame;
            end else if ((r_state == StData) && r_fall) begin
                r_shift <= {1'b0, r_shift[8:1]};
            end
            if (r_state != StData) begin
                r_bit <= '0;
            end else if (r_fall) begin
                r_bit <= r_bit + 4'd1;
            end
            if ((r_state == StAck) && r_fall) begin
                r_nak <= r_d_sync[1];
            end
        end
    end

    // Line drive is gated by reset so both lines release within the reset cycle.
    always_comb begin
        w_c_low = reset && (r_state == StRequest);
        w_d_low = reset && ((r_state == StStart) || ((r_state == StData) && !r_shift[0]));
    end

    assign ps2c     = w_c_low ? 1'b0 : 1'bz;
    assign ps2d     = w_d_low ? 1'b0 : 1'bz;
    assign tx_ready = (r_state == StIdle) && !r_done && !r_err;
    assign busy     = (r_state != StIdle);
    assign tx_done  = r_done;
    assign tx_err   = r_err;
    assign err_code = r_err_code;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a simple PS/2 device model on pulled-up lines.
`timescale 1ns/1ps
module tb_ps2_host_tx;

    localparam int unsigned RC = 20;
    localparam int unsigned FL = 4;
    localparam int unsigned TO = 300;
    localparam int unsigned MR = 2;
    localparam int HALF = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_abort = 1'b0;
    logic       tx_ready, tx_done, tx_err, busy;
    logic [1:0] err_code;
    wire        ps2c, ps2d;
    logic       dev_c_low = 1'b0;
    logic       dev_d_low = 1'b0;

    int n_checks = 0, n_errors = 0;
    int n_done = 0, n_err = 0, n_both = 0, n_bad_ready = 0, n_req = 0;
    int cyc = 0, fall_cyc = 0;
    bit req_prev = 1'b0;

    assign ps2c = dev_c_low ? 1'b0 : 1'bz;
    assign ps2d = dev_d_low ? 1'b0 : 1'bz;
    pullup (ps2c);
    pullup (ps2d);

    always #5 clk = ~clk;

    ps2_host_tx #(
        .REQUEST_CYCLES(RC),
        .FILTER_LEN    (FL),
        .TIMEOUT_CYCLES(TO),
        .MAX_RETRIES   (MR),
        .ODD_PARITY    (1'b1)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .tx_abort(tx_abort),
        .tx_done (tx_done),
        .tx_err  (tx_err),
        .err_code(err_code),
        .busy    (busy),
        .ps2d    (ps2d),
        .ps2c    (ps2c)
    );

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if ((ps2c === 1'b0) && !dev_c_low && !req_prev) n_req <= n_req + 1;
        req_prev <= (ps2c === 1'b0) && !dev_c_low;
    end

    always @(negedge clk) begin
        if (tx_done) n_done++;
        if (tx_err) n_err++;
        if (tx_done && tx_err) n_both++;
        if (busy && tx_ready) n_bad_ready++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("ready_for_send", 32'(ok), 32'd1);
        tx_data  = b;
        tx_valid = 1'b1;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        tx_data  = ~b;
    endtask

    task automatic measure_request(output int n);
        n = 0;
        for (int i = 0; i < 4 * RC; i++) begin
            @(negedge clk);
            if (ps2c === 1'b0) n++;
            else break;
        end
    endtask

    // Device side: wait for START, then clock up to stop_after falls; ACK or NAK at fall 11/12.
    task automatic dev_frame(input bit nak, input int stop_after, input bit glitch,
                             output logic [9:0] bits);
        bit seen;
        seen = 1'b0;
        bits = '0;
        for (int i = 0; i < 4 * RC + 200; i++) begin
            @(negedge clk);
            if ((ps2c === 1'b1) && (ps2d === 1'b0)) begin
                seen = 1'b1;
                break;
            end
        end
        check("start_seen", 32'(seen), 32'd1);
        if (!seen) return;
        repeat (HALF) @(negedge clk);
        for (int k = 1; (k <= 12) && (k <= stop_after); k++) begin
            dev_c_low = 1'b1;
            fall_cyc  = cyc;
            repeat (HALF) @(negedge clk);
            dev_c_low = 1'b0;
            if (k == 12) begin
                @(negedge clk);
                dev_d_low = 1'b0;
            end else begin
                repeat (HALF / 2) @(negedge clk);
                if (k <= 10) bits[k-1] = ps2d;
                if (k == 11) dev_d_low = !nak;
                if (glitch && (k >= 2) && (k <= 9)) begin
                    dev_c_low = 1'b1;
                    repeat (FL - 1) @(negedge clk);
                    dev_c_low = 1'b0;
                    repeat (HALF / 2 - (FL - 1)) @(negedge clk);
                end else begin
                    repeat (HALF - HALF / 2) @(negedge clk);
                end
            end
        end
    endtask

    task automatic wait_end(input int limit, output bit got_done, output bit got_err,
                            output int at_cyc);
        bit got;
        got = 1'b0;
        got_done = 1'b0;
        got_err = 1'b0;
        at_cyc = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (tx_done || tx_err) begin
                got = 1'b1;
                got_done = tx_done;
                got_err = tx_err;
                at_cyc = cyc;
                break;
            end
        end
        check("pulse_seen", 32'(got), 32'd1);
        if (got) begin
            check("ready_in_pulse", 32'(tx_ready), 32'd0);
            @(negedge clk);
            check("ready_after_pulse", 32'(tx_ready), 32'd1);
        end
    endtask

    initial begin
        logic [9:0] bits;
        int  lc, at, d0, e0, r0, delta;
        bit  gd, ge;

        repeat (3) @(negedge clk);
        check("rst_ready", 32'(tx_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(tx_done), 32'd0);
        check("rst_err", 32'(tx_err), 32'd0);
        check("rst_code", 32'(err_code), 32'd0);
        check("rst_ps2c", 32'(ps2c), 32'd1);
        check("rst_ps2d", 32'(ps2d), 32'd1);
        reset = 1'b1;

        // 8'hED, ACKed: data LSB first then odd parity 1 and stop 1
        d0 = n_done;
        send(8'hED);
        measure_request(lc);
        check("ed_req_len", 32'(lc), RC);
        dev_frame(1'b0, 12, 1'b0, bits);
        check("ed_bits", 32'(bits), 32'h3ED);
        wait_end(100, gd, ge, at);
        check("ed_done", 32'(gd), 32'd1);
        check("ed_err", 32'(ge), 32'd0);
        check("ed_code", 32'(err_code), 32'd0);
        check("ed_done_count", 32'(n_done - d0), 32'd1);

        // 8'h00: parity 1, request length exact
        send(8'h00);
        measure_request(lc);
        check("z_req_len", 32'(lc), RC);
        dev_frame(1'b0, 12, 1'b0, bits);
        check("z_bits", 32'(bits), 32'h300);
        wait_end(100, gd, ge, at);
        check("z_done", 32'(gd), 32'd1);

        // Three NAKs exhaust two retries
        d0 = n_done;
        r0 = n_req;
        send(8'hF0);
        for (int r = 0; r < 3; r++) begin
            dev_frame(1'b1, 12, 1'b0, bits);
            check("nak_bits", 32'(bits), 32'h3F0);
        end
        wait_end(100, gd, ge, at);
        check("nak_err", 32'(ge), 32'd1);
        check("nak_code", 32'(err_code), 32'd2);
        check("nak_requests", 32'(n_req - r0), 32'd3);
        check("nak_no_done", 32'(n_done - d0), 32'd0);

        // One NAK then ACK
        d0 = n_done;
        e0 = n_err;
        send(8'h5A);
        dev_frame(1'b1, 12, 1'b0, bits);
        check("retry_bits1", 32'(bits), 32'h35A);
        dev_frame(1'b0, 12, 1'b0, bits);
        check("retry_bits2", 32'(bits), 32'h35A);
        wait_end(100, gd, ge, at);
        check("retry_done", 32'(n_done - d0), 32'd1);
        check("retry_no_err", 32'(n_err - e0), 32'd0);
        check("retry_code", 32'(err_code), 32'd0);

        // Device stops after fall 5; d4 of 8'h02 is 0 so data is actively driven
        send(8'h02);
        dev_frame(1'b0, 5, 1'b0, bits);
        wait_end(TO + 50, gd, ge, at);
        delta = at - fall_cyc;
        check("to_err", 32'(ge), 32'd1);
        check("to_window", 32'((delta >= int'(TO) + 1) && (delta <= int'(TO + FL) + 4)), 32'd1);
        check("to_code", 32'(err_code), 32'd1);
        check("to_ps2c", 32'(ps2c), 32'd1);
        check("to_ps2d", 32'(ps2d), 32'd1);

        // Sub-filter glitches on ps2c must not advance bits; odd-weight byte gives parity 0
        send(8'hA7);
        dev_frame(1'b0, 12, 1'b1, bits);
        check("glitch_bits", 32'(bits), 32'h2A7);
        wait_end(100, gd, ge, at);
        check("glitch_done", 32'(gd), 32'd1);

        // Abort mid-DATA while d3=0 is driven
        send(8'hC3);
        check("abort_code_cleared", 32'(err_code), 32'd0);
        dev_frame(1'b0, 4, 1'b0, bits);
        check("abort_pre_ps2d", 32'(ps2d), 32'd0);
        d0 = n_done;
        e0 = n_err;
        tx_abort = 1'b1;
        @(negedge clk);
        tx_abort = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_ps2d", 32'(ps2d), 32'd1);
        check("abort_ps2c", 32'(ps2c), 32'd1);
        repeat (TO + 50) @(negedge clk);
        check("abort_no_pulse", 32'((n_done - d0) + (n_err - e0)), 32'd0);
        check("abort_ready", 32'(tx_ready), 32'd1);

        // Reset during REQUEST releases ps2c within the reset cycle
        send(8'h55);
        repeat (5) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rreq_ps2c", 32'(ps2c), 32'd1);
        @(negedge clk);
        check("rreq_busy", 32'(busy), 32'd0);
        reset = 1'b1;

        // Reset mid-STOP
        send(8'h81);
        dev_frame(1'b0, 10, 1'b0, bits);
        check("rstop_bits", 32'(bits), 32'h381);
        d0 = n_done;
        e0 = n_err;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("rstop_busy", 32'(busy), 32'd0);
        check("rstop_ready", 32'(tx_ready), 32'd1);
        check("rstop_ps2c", 32'(ps2c), 32'd1);
        check("rstop_ps2d", 32'(ps2d), 32'd1);
        repeat (TO + 50) @(negedge clk);
        check("rstop_no_pulse", 32'((n_done - d0) + (n_err - e0)), 32'd0);

        check("both_pulses", 32'(n_both), 32'd0);
        check("ready_while_busy", 32'(n_bad_ready), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
